if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter RESET_PC, 64'h0, byte address of the first instruction fetched after reset.
REQ-002 SHALL have port clk  input  1  single rising-edge clock for all state.
REQ-003 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port imem_req  output  1  instruction-memory request.
REQ-005 SHALL have port imem_addr  output  64  fetch byte address; valid while imem_req=1.
REQ-006 SHALL have port imem_ack  input  1  one-cycle response strobe; imem_rdata valid in that cycle.
REQ-007 SHALL have port imem_rdata  input  32  fetched instruction word.
REQ-008 SHALL have port stall  input  1  downstream cannot accept a new IF/ID entry this cycle.
REQ-009 SHALL have port branch_taken  input  1  one-cycle redirect strobe from execute.
REQ-010 SHALL have port branch_pc  input  64  PC of the redirecting branch.
REQ-011 SHALL have port imm_ext  input  64  sign-extended offset from the sign-extension unit, in instruction words.
REQ-012 SHALL have ports ifid_valid (output 1), ifid_pc (output 64), ifid_instr (output 32): the IF/ID entry.
REQ-013 SHALL have port seu_addr  output  26  ifid_instr[25:0], feeding the sign-extension unit.
REQ-014 SHALL have port seu_sel  output  2  extension-format select, decoded from ifid_instr.

Function
REQ-015 SHALL use states FETCH, HOLD, DRAIN; imem_req=1 in FETCH and DRAIN, 0 in HOLD and whenever reset=1.
REQ-016 SHALL drive imem_addr from the registered pc, which changes only on ack, redirect or reset, never while a request is pending unacknowledged.
REQ-017 FETCH, ack, branch_taken=0, (ifid_valid=0 or stall=0): ifid_instr<=imem_rdata, ifid_pc<=pc, ifid_valid<=1, pc<=pc+4, stay FETCH.
REQ-018 FETCH, ack, branch_taken=0, ifid_valid=1 and stall=1: word into skid register (with its pc), pc<=pc+4, go HOLD.
REQ-019 FETCH, no ack, ifid_valid=1, stall=0: ifid_valid<=0 (entry consumed, no bubble-hold).
REQ-020 HOLD, stall=0: IF/ID loads skid word and pc, ifid_valid<=1, go FETCH; stall=1: IF/ID and skid unchanged.
REQ-021 stall=1 SHALL hold ifid_valid/ifid_pc/ifid_instr unchanged (except on branch).
REQ-022 branch_taken=1 SHALL set pc<=branch_pc+(imm_ext<<2) (64-bit wrap, overflow ignored), ifid_valid<=0, skid cleared, regardless of stall.
REQ-023 Branch in FETCH without same-cycle ack SHALL go DRAIN; with same-cycle ack, discard the word and stay FETCH.
REQ-024 DRAIN SHALL hold imem_req=1 and the pre-redirect address until ack, discard that word, then go FETCH at the new pc.
REQ-025 Branch in HOLD SHALL go FETCH; branch in DRAIN SHALL update pc and stay DRAIN.
REQ-026 seu_sel SHALL be 2'b10 when ifid_instr[31:26]=000101 (B); 2'b11 when [31:24] is 10110100, 10110101 or 01010100 (CBZ/CBNZ/B.cond); 2'b01 when [31:21] is 11111000010 or 11111000000 (LDUR/STUR); else 2'b00.
REQ-027 pc+4 SHALL wrap modulo 2^64; fetch latency from request to IF/ID is ack cycle + 1.

Reset
REQ-028 reset=1 SHALL force state FETCH, pc=RESET_PC, ifid_valid=0, ifid_pc=0, ifid_instr=0, skid cleared; imem_ack ignored during reset.
REQ-029 Reset mid-transaction SHALL abandon any outstanding request (memory shares the reset); first request issues in the cycle after reset deasserts.

Structure
REQ-030 SHALL place state encoding, opcode constants and seu_sel codes (ALU_IMM, DT_ADDR, BR_ADDR, CB_ADDR) in a shared package.
REQ-031 SHALL implement REQ-026 as combinational sub-module seu_sel_decode.

Verification
REQ-032 Reset, RESET_PC=0, ack every 2nd cycle -> addresses 0,4,8 issued in order; ifid_pc 0,4,8 with matching words.
REQ-033 ifid_valid=1, stall=1 for 4 cycles, ack arrives -> HOLD, req=0, IF/ID unchanged; stall drops -> skid word appears next cycle, no loss or duplicate.
REQ-034 branch_taken with branch_pc=0x100, imm_ext=-2 while request pending -> DRAIN, stale word discarded, next imem_addr=0xF8, ifid_valid=0.
REQ-035 branch_taken coincident with ack and stall=1 -> word discarded, ifid_valid=0, next imem_addr=target.
REQ-036 ifid_instr 0x14000003, 0xB4000040, 0xF8408020, 0x91000421 -> seu_sel 10, 11, 01, 00; seu_addr = low 26 bits.
REQ-037 reset asserted mid-DRAIN with ack in same cycle -> ack ignored, pc=RESET_PC, ifid_valid=0.

Source files
------------

// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encoding, opcode
// patterns used to pick the sign-extension format, and the format codes.
package if_stage_pkg;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_e;

  localparam logic [1:0] ALU_IMM = 2'b00;
  localparam logic [1:0] DT_ADDR = 2'b01;
  localparam logic [1:0] BR_ADDR = 2'b10;
  localparam logic [1:0] CB_ADDR = 2'b11;

  localparam logic [5:0]  OP_B     = 6'b000101;
  localparam logic [7:0]  OP_CBZ   = 8'b10110100;
  localparam logic [7:0]  OP_CBNZ  = 8'b10110101;
  localparam logic [7:0]  OP_BCOND = 8'b01010100;
  localparam logic [10:0] OP_LDUR  = 11'b11111000010;
  localparam logic [10:0] OP_STUR  = 11'b11111000000;

endpackage

// File: rtl/if_stage_seu_sel_decode.sv
// Combinational decode of the opcode field into the sign-extension format
// select. Only bits [31:21] of the instruction matter here.
module seu_sel_decode
  import if_stage_pkg::*;
(
  input  logic [10:0] op_i,
  output logic [1:0]  sel_o
);

  always_comb begin
    sel_o = ALU_IMM;
    if (op_i[10:5] == OP_B) begin
      sel_o = BR_ADDR;
    end else if (op_i[10:3] == OP_CBZ || op_i[10:3] == OP_CBNZ ||
                 op_i[10:3] == OP_BCOND) begin
      sel_o = CB_ADDR;
    end else if (op_i == OP_LDUR || op_i == OP_STUR) begin
      sel_o = DT_ADDR;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: issues fetches to instruction memory, fills the
// IF/ID entry, absorbs one word of downstream stall in a skid register.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic         clk,
  input  logic         reset,
  output logic         imem_req,
  output logic [63:0]  imem_addr,
  input  logic         imem_ack,
  input  logic [31:0]  imem_rdata,
  input  logic         stall,
  input  logic         branch_taken,
  input  logic [63:0]  branch_pc,
  input  logic [63:0]  imm_ext,
  output logic         ifid_valid,
  output logic [63:0]  ifid_pc,
  output logic [31:0]  ifid_instr,
  output logic [25:0]  seu_addr,
  output logic [1:0]   seu_sel,
  output fetch_state_e dbg_state_o
);

  // Handshake: imem_req stays high with imem_addr stable until a single-cycle
  // imem_ack returns the word; ack is only meaningful while imem_req is high.
  fetch_state_e state_q;
  logic [63:0]  pc_q;
  logic [63:0]  drain_addr_q;
  logic [63:0]  skid_pc_q;
  logic [31:0]  skid_instr_q;
  logic         ifid_valid_q;
  logic [63:0]  ifid_pc_q;
  logic [31:0]  ifid_instr_q;

  logic [63:0]  pc_inc_d;
  logic [63:0]  br_target_d;

  assign pc_inc_d    = pc_q + 64'd4;
  assign br_target_d = branch_pc + (imm_ext << 2);

  // While draining, the memory still owns the pre-redirect address.
  assign imem_req  = !reset && (state_q != ST_HOLD);
  assign imem_addr = (state_q == ST_DRAIN) ? drain_addr_q : pc_q;

  assign ifid_valid  = ifid_valid_q;
  assign ifid_pc     = ifid_pc_q;
  assign ifid_instr  = ifid_instr_q;
  assign seu_addr    = ifid_instr_q[25:0];
  assign dbg_state_o = state_q;

  seu_sel_decode u_seu_sel_decode (
    .op_i  (ifid_instr_q[31:21]),
    .sel_o (seu_sel)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_FETCH;
      pc_q         <= RESET_PC;
      drain_addr_q <= '0;
      skid_pc_q    <= '0;
      skid_instr_q <= '0;
      ifid_valid_q <= 1'b0;
      ifid_pc_q    <= '0;
      ifid_instr_q <= '0;
    end else if (branch_taken) begin
      pc_q         <= br_target_d;
      ifid_valid_q <= 1'b0;
      skid_pc_q    <= '0;
      skid_instr_q <= '0;
      case (state_q)
        ST_FETCH: begin
          if (!imem_ack) begin
            state_q      <= ST_DRAIN;
            drain_addr_q <= pc_q;
          end
        end
        ST_HOLD:  state_q <= ST_FETCH;
        // A drain ack arriving with the redirect completes the drain.
        default:  if (imem_ack) state_q <= ST_FETCH;
      endcase
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (imem_ack) begin
            pc_q <= pc_inc_d;
            if (!ifid_valid_q || !stall) begin
              ifid_valid_q <= 1'b1;
              ifid_pc_q    <= pc_q;
              ifid_instr_q <= imem_rdata;
            end else begin
              skid_pc_q    <= pc_q;
              skid_instr_q <= imem_rdata;
              state_q      <= ST_HOLD;
            end
          end else if (ifid_valid_q && !stall) begin
            ifid_valid_q <= 1'b0;
          end
        end
        ST_HOLD: begin
          if (!stall) begin
            ifid_valid_q <= 1'b1;
            ifid_pc_q    <= skid_pc_q;
            ifid_instr_q <= skid_instr_q;
            state_q      <= ST_FETCH;
          end
        end
        default: begin
          if (imem_ack) state_q <= ST_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: fetch ordering, stall skid, redirects,
// opcode format decode, pc wrap and reset during a drain.
module tb_if_stage;
  import if_stage_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  logic         imem_req;
  logic [63:0]  imem_addr;
  logic         imem_ack;
  logic [31:0]  imem_rdata;
  logic         stall;
  logic         branch_taken;
  logic [63:0]  branch_pc;
  logic [63:0]  imm_ext;
  logic         ifid_valid;
  logic [63:0]  ifid_pc;
  logic [31:0]  ifid_instr;
  logic [25:0]  seu_addr;
  logic [1:0]   seu_sel;
  fetch_state_e dbg_state;

  int tests_run = 0;
  int tests_failed = 0;

  if_stage #(.RESET_PC(64'h0)) dut (
    .clk          (clk),
    .reset        (reset),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_pc    (branch_pc),
    .imm_ext      (imm_ext),
    .ifid_valid   (ifid_valid),
    .ifid_pc      (ifid_pc),
    .ifid_instr   (ifid_instr),
    .seu_addr     (seu_addr),
    .seu_sel      (seu_sel),
    .dbg_state_o  (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; imem_ack = 1'b0; imem_rdata = '0; stall = 1'b0;
    branch_taken = 1'b0; branch_pc = '0; imm_ext = '0;
    cyc();
    imem_ack = 1'b1; imem_rdata = 32'hCAFE_0000;
    #1;
    chk("req_in_reset", 64'(imem_req), 64'd0);
    cyc();
    chk("rst_valid", 64'(ifid_valid), 64'd0);
    chk("rst_pc", ifid_pc, 64'h0);
    chk("rst_instr", 64'(ifid_instr), 64'h0);
    chk("rst_state", 64'(dbg_state), 64'(ST_FETCH));

    // In-order fetch with an ack every second cycle.
    reset = 1'b0; imem_ack = 1'b0;
    #1;
    chk("first_req", 64'(imem_req), 64'd1);
    chk("addr0", imem_addr, 64'h0);
    cyc();
    imem_ack = 1'b1; imem_rdata = 32'h1111_0000;
    cyc();
    imem_ack = 1'b0;
    chk("w0_valid", 64'(ifid_valid), 64'd1);
    chk("w0_pc", ifid_pc, 64'h0);
    chk("w0_instr", 64'(ifid_instr), 64'h1111_0000);
    chk("addr4", imem_addr, 64'h4);
    cyc();
    chk("consumed", 64'(ifid_valid), 64'd0);
    imem_ack = 1'b1; imem_rdata = 32'h1111_0004;
    cyc();
    imem_ack = 1'b0;
    chk("w1_pc", ifid_pc, 64'h4);
    chk("w1_instr", 64'(ifid_instr), 64'h1111_0004);
    chk("addr8", imem_addr, 64'h8);
    cyc();
    imem_ack = 1'b1; imem_rdata = 32'h1111_0008;
    cyc();
    imem_ack = 1'b0;
    chk("w2_pc", ifid_pc, 64'h8);
    chk("w2_instr", 64'(ifid_instr), 64'h1111_0008);

    // Four stalled cycles with an ack in the third.
    stall = 1'b1;
    cyc();
    chk("stall_hold_pc", ifid_pc, 64'h8);
    chk("stall_hold_valid", 64'(ifid_valid), 64'd1);
    cyc();
    imem_ack = 1'b1; imem_rdata = 32'h1111_000C;
    cyc();
    imem_ack = 1'b0;
    chk("hold_state", 64'(dbg_state), 64'(ST_HOLD));
    chk("hold_req", 64'(imem_req), 64'd0);
    chk("hold_ifid_instr", 64'(ifid_instr), 64'h1111_0008);
    cyc();
    chk("hold2_state", 64'(dbg_state), 64'(ST_HOLD));
    chk("hold2_ifid_pc", ifid_pc, 64'h8);
    stall = 1'b0;
    cyc();
    chk("skid_valid", 64'(ifid_valid), 64'd1);
    chk("skid_pc", ifid_pc, 64'hC);
    chk("skid_instr", 64'(ifid_instr), 64'h1111_000C);
    chk("after_skid_state", 64'(dbg_state), 64'(ST_FETCH));
    chk("after_skid_addr", imem_addr, 64'h10);
    cyc();
    chk("no_dup", 64'(ifid_valid), 64'd0);
    imem_ack = 1'b1; imem_rdata = 32'h1111_0010;
    cyc();
    imem_ack = 1'b0;
    chk("w4_pc", ifid_pc, 64'h10);

    // Redirect while the fetch at 0x14 is outstanding.
    branch_taken = 1'b1; branch_pc = 64'h100; imm_ext = 64'hFFFF_FFFF_FFFF_FFFE;
    cyc();
    branch_taken = 1'b0;
    chk("drain_state", 64'(dbg_state), 64'(ST_DRAIN));
    chk("drain_valid", 64'(ifid_valid), 64'd0);
    chk("drain_req", 64'(imem_req), 64'd1);
    chk("drain_addr", imem_addr, 64'h14);
    cyc();
    chk("drain_addr_held", imem_addr, 64'h14);
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    cyc();
    imem_ack = 1'b0;
    chk("drain_done_state", 64'(dbg_state), 64'(ST_FETCH));
    chk("drain_discard", 64'(ifid_valid), 64'd0);
    chk("target_addr", imem_addr, 64'hF8);

    // Redirect coincident with ack under stall.
    imem_ack = 1'b1; imem_rdata = 32'h2222_00F8;
    cyc();
    chk("w5_pc", ifid_pc, 64'hF8);
    stall = 1'b1; imem_rdata = 32'h2222_00FC;
    branch_taken = 1'b1; branch_pc = 64'h200; imm_ext = 64'h3;
    cyc();
    imem_ack = 1'b0; branch_taken = 1'b0; stall = 1'b0;
    chk("br_ack_state", 64'(dbg_state), 64'(ST_FETCH));
    chk("br_ack_valid", 64'(ifid_valid), 64'd0);
    chk("br_ack_addr", imem_addr, 64'h20C);

    // Format select across opcode classes, back-to-back acks.
    imem_ack = 1'b1; imem_rdata = 32'h1400_0003;
    cyc();
    chk("b_pc", ifid_pc, 64'h20C);
    chk("b_sel", 64'(seu_sel), 64'(BR_ADDR));
    chk("b_addr", 64'(seu_addr), 64'h000_0003);
    imem_rdata = 32'hB400_0040;
    cyc();
    chk("cbz_sel", 64'(seu_sel), 64'(CB_ADDR));
    chk("cbz_addr", 64'(seu_addr), 64'h000_0040);
    imem_rdata = 32'hF840_8020;
    cyc();
    chk("ldur_sel", 64'(seu_sel), 64'(DT_ADDR));
    chk("ldur_addr", 64'(seu_addr), 64'h040_8020);
    imem_rdata = 32'h9100_0421;
    cyc();
    imem_ack = 1'b0;
    chk("alu_sel", 64'(seu_sel), 64'(ALU_IMM));
    chk("alu_addr", 64'(seu_addr), 64'h100_0421);
    chk("alu_pc", ifid_pc, 64'h218);

    // pc wraps past the top of the address space.
    branch_taken = 1'b1; branch_pc = 64'hFFFF_FFFF_FFFF_FFF8; imm_ext = 64'h1;
    cyc();
    branch_taken = 1'b0;
    imem_ack = 1'b1; imem_rdata = 32'h0;
    cyc();
    chk("wrap_target", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    imem_rdata = 32'h3333_3333;
    cyc();
    imem_ack = 1'b0;
    chk("wrap_ifid_pc", ifid_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_addr", imem_addr, 64'h0);

    // Reset with an ack while draining.
    branch_taken = 1'b1; branch_pc = 64'h40; imm_ext = 64'h0;
    cyc();
    branch_taken = 1'b0;
    chk("pre_rst_state", 64'(dbg_state), 64'(ST_DRAIN));
    reset = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h4444_4444;
    #1;
    chk("rst_drain_req", 64'(imem_req), 64'd0);
    cyc();
    reset = 1'b0; imem_ack = 1'b0;
    #1;
    chk("rst_drain_state", 64'(dbg_state), 64'(ST_FETCH));
    chk("rst_drain_valid", 64'(ifid_valid), 64'd0);
    chk("rst_drain_instr", 64'(ifid_instr), 64'h0);
    chk("rst_drain_addr", imem_addr, 64'h0);
    chk("rst_drain_req1", 64'(imem_req), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
